// File: rtl/inst_pkg.sv
// Shared definitions for the instruction fetch stage: widths, opcode field
// position, HALT encoding and the fetch state type.
package inst_pkg;

  localparam int DEF_ADDR_W = 5;
  localparam int DEF_CODE_W = 23;

  localparam int OPC_MSB = 22;
  localparam int OPC_LSB = 19;
  localparam logic [OPC_MSB-OPC_LSB:0] OPC_HALT = 4'hF;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    HOLD   = 2'd1,
    HALTED = 2'd2
  } fetch_state_t;

  function automatic logic op_is_halt(input logic [DEF_CODE_W-1:0] code);
    return code[OPC_MSB:OPC_LSB] == OPC_HALT;
  endfunction

endpackage

// File: rtl/pc_counter.sv
// Program counter register: async active-low clear, load, wrapping increment
// or hold. This is the only storage for the fetch address.
module pc_counter
  import inst_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic              inc,
  output logic [ADDR_W-1:0] pc
);

  logic [ADDR_W-1:0] pc_reg;
  logic [ADDR_W-1:0] pc_next;

  // Load outranks increment so a jump always wins over sequential fetch.
  always_comb begin
    pc_next = pc_reg;
    if (load) begin
      pc_next = load_addr;
    end else if (inc) begin
      pc_next = pc_reg + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_reg <= '0;
    end else begin
      pc_reg <= pc_next;
    end
  end

  assign pc = pc_reg;

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch stage: PC, ROM address, instruction register and a
// valid/ready handoff to the decoder. Optional macro FETCH_PIPELINE_EN enables
// back-to-back fetch (1 instruction/cycle); default build is 1 per 2 cycles.
module inst_fetch
  import inst_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int CODE_W = DEF_CODE_W
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [CODE_W-1:0] rom_code,
  output logic [CODE_W-1:0] inst,
  output logic              inst_valid,
  input  logic              inst_ready,
  input  logic              jump_en,
  input  logic [ADDR_W-1:0] jump_addr,
  output logic [ADDR_W-1:0] pc,
  output logic              halted
);

  fetch_state_t      state_reg;
  fetch_state_t      state_next;
  logic [CODE_W-1:0] ir_reg;
  logic [CODE_W-1:0] ir_next;
  logic              valid_reg;
  logic              valid_next;
  logic              halted_reg;
  logic              halted_next;

  logic              pc_load;
  logic              pc_inc;
  logic              consume;
  logic              ir_is_halt;
  logic [ADDR_W-1:0] pc_value;

  pc_counter #(
    .ADDR_W (ADDR_W)
  ) u_pc_counter (
    .clk       (clk),
    .rst       (rst),
    .load      (pc_load),
    .load_addr (jump_addr),
    .inc       (pc_inc),
    .pc        (pc_value)
  );

  assign consume    = valid_reg && inst_ready;
  assign ir_is_halt = (ir_reg[OPC_MSB:OPC_LSB] == OPC_HALT);

  always_comb begin
    state_next  = state_reg;
    ir_next     = ir_reg;
    valid_next  = valid_reg;
    halted_next = halted_reg;
    pc_load     = 1'b0;
    pc_inc      = 1'b0;

    // A jump overrides everything; a coincident consume still completes on
    // the decoder side, but nothing sequential is loaded here.
    if (jump_en) begin
      state_next  = FETCH;
      valid_next  = 1'b0;
      halted_next = 1'b0;
      pc_load     = 1'b1;
    end else begin
      case (state_reg)
        FETCH: begin
          ir_next    = rom_code;
          valid_next = 1'b1;
          pc_inc     = 1'b1;
          state_next = HOLD;
        end
        HOLD: begin
          if (consume) begin
            if (ir_is_halt) begin
              valid_next  = 1'b0;
              halted_next = 1'b1;
              state_next  = HALTED;
            end else begin
`ifdef FETCH_PIPELINE_EN
              ir_next    = rom_code;
              pc_inc     = 1'b1;
`else
              valid_next = 1'b0;
              state_next = FETCH;
`endif
            end
          end
        end
        HALTED: begin
          state_next = HALTED;
        end
        default: begin
          state_next  = FETCH;
          valid_next  = 1'b0;
          halted_next = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg  <= FETCH;
      ir_reg     <= '0;
      valid_reg  <= 1'b0;
      halted_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      ir_reg     <= ir_next;
      valid_reg  <= valid_next;
      halted_reg <= halted_next;
    end
  end

  assign pc         = pc_value;
  assign rom_addr   = pc_value;
  assign inst       = ir_reg;
  assign inst_valid = valid_reg;
  assign halted     = halted_reg;

endmodule
